// File: rtl/bounded_step_counter.sv
// rtl/bounded_step_counter.sv - bounded up/down counter with programmable step, bounds, saturate/wrap modes
module bounded_step_counter #(
  parameter int COUNT_SIZE = 8,
  parameter int STEP_SIZE  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  up,
  input  logic                  down,
  input  logic                  load,
  input  logic [COUNT_SIZE-1:0] in,
  input  logic                  load_max,
  input  logic [COUNT_SIZE-1:0] max_in,
  input  logic                  load_min,
  input  logic [COUNT_SIZE-1:0] min_in,
  input  logic [STEP_SIZE-1:0]  step,
  input  logic                  wrap_mode,
  input  logic                  flag_clr,
  output logic [COUNT_SIZE-1:0] out,
  output logic                  at_max,
  output logic                  at_min,
  output logic                  wrap,
  output logic                  sat,
  output logic                  cfg_err
);

  // One extra bit so sums carry and differences borrow visibly instead of wrapping.
  localparam int W = COUNT_SIZE + 1;

  logic [COUNT_SIZE-1:0] cnt_q, cnt_d;
  logic [COUNT_SIZE-1:0] max_q, max_d;
  logic [COUNT_SIZE-1:0] min_q, min_d;
  logic                  at_max_q, at_max_d;
  logic                  at_min_q, at_min_d;
  logic                  wrap_q, wrap_d;
  logic                  sat_q, sat_d;
  logic                  sat_set;
  logic                  wrap_set;

  logic [W-1:0] cnt_x, max_x, min_x, step_x, sum_x, diff_x;

  assign cnt_x  = {1'b0, cnt_q};
  assign max_x  = {1'b0, max_q};
  assign min_x  = {1'b0, min_q};
  assign step_x = {{(W-STEP_SIZE){1'b0}}, step};
  assign sum_x  = cnt_x + step_x;
  assign diff_x = cnt_x - step_x;

  assign cfg_err = (min_q > max_q);

  // Next count: clr > load > single-direction step > hold/clamp, all against the old bounds.
  always_comb begin
    cnt_d    = cnt_q;
    sat_set  = 1'b0;
    wrap_set = 1'b0;
    if (clr) begin
      cnt_d = min_q;
    end else if (!cfg_err) begin
      if (load) begin
        if (in > max_q) begin
          cnt_d   = max_q;
          sat_set = 1'b1;
        end else if (in < min_q) begin
          cnt_d   = min_q;
          sat_set = 1'b1;
        end else begin
          cnt_d = in;
        end
      end else if ((up ^ down) && (step != '0)) begin
        if (up) begin
          if (sum_x > max_x) begin
            if (wrap_mode) begin
              cnt_d    = min_q;
              wrap_set = 1'b1;
            end else begin
              cnt_d   = max_q;
              sat_set = 1'b1;
            end
          end else begin
            cnt_d = sum_x[COUNT_SIZE-1:0];
          end
        end else begin
          if ((cnt_x < step_x) || (diff_x < min_x)) begin
            if (wrap_mode) begin
              cnt_d    = max_q;
              wrap_set = 1'b1;
            end else begin
              cnt_d   = min_q;
              sat_set = 1'b1;
            end
          end else begin
            cnt_d = diff_x[COUNT_SIZE-1:0];
          end
        end
      end else begin
        // A bound change can strand the count outside the window; pull it back quietly.
        if (cnt_q > max_q) begin
          cnt_d = max_q;
        end else if (cnt_q < min_q) begin
          cnt_d = min_q;
        end
      end
    end
  end

  // Bound updates and registered flags derived from the next count and current bounds.
  always_comb begin
    max_d    = load_max ? max_in : max_q;
    min_d    = load_min ? min_in : min_q;
    at_max_d = (cnt_d == max_q);
    at_min_d = (cnt_d == min_q);
    wrap_d   = wrap_set;
    sat_d    = sat_set | (sat_q & ~flag_clr);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      max_q    <= '1;
      min_q    <= '0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
      wrap_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      min_q    <= min_d;
      at_max_q <= at_max_d;
      at_min_q <= at_min_d;
      wrap_q   <= wrap_d;
      sat_q    <= sat_d;
    end
  end

  assign out    = cnt_q;
  assign at_max = at_max_q;
  assign at_min = at_min_q;
  assign wrap   = wrap_q;
  assign sat    = sat_q;

endmodule

// File: tb/tb_bounded_step_counter.sv
// tb/tb_bounded_step_counter.sv - directed self-checking bench for bounded_step_counter
module tb_bounded_step_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0, up = 1'b0, down = 1'b0, load = 1'b0;
  logic [7:0] in = '0;
  logic       load_max = 1'b0, load_min = 1'b0;
  logic [7:0] max_in = '0, min_in = '0;
  logic [3:0] step = '0;
  logic       wrap_mode = 1'b0, flag_clr = 1'b0;
  logic [7:0] out;
  logic       at_max, at_min, wrap, sat, cfg_err;

  int passed = 0;
  int total  = 0;

  bounded_step_counter #(.COUNT_SIZE(8), .STEP_SIZE(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .up(up), .down(down), .load(load), .in(in),
    .load_max(load_max), .max_in(max_in), .load_min(load_min), .min_in(min_in),
    .step(step), .wrap_mode(wrap_mode), .flag_clr(flag_clr),
    .out(out), .at_max(at_max), .at_min(at_min), .wrap(wrap), .sat(sat), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Return all control inputs to idle.
  task automatic idle();
    clr = 0; up = 0; down = 0; load = 0; load_max = 0; load_min = 0;
    flag_clr = 0; step = 0; wrap_mode = 0; in = 0; max_in = 0; min_in = 0;
  endtask

  // Advance one rising edge; returns at the following falling edge for sampling and driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 0;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out !== 8'd0) $display("FAIL reset_out act=%0d exp=0", out); else passed++;
    total++; if ({at_max, at_min, wrap, sat, cfg_err} !== 5'b01000)
      $display("FAIL reset_flags act=%b exp=01000", {at_max, at_min, wrap, sat, cfg_err}); else passed++;
  endtask

  task automatic test_up_saturate();
    logic [7:0] exp_out [8];
    exp_out = '{8'd3, 8'd6, 8'd9, 8'd12, 8'd15, 8'd18, 8'd20, 8'd20};
    do_reset();
    load_max = 1; max_in = 8'd20;
    tick();
    idle();
    up = 1; step = 4'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (out !== exp_out[i]) $display("FAIL up_sat_out[%0d] act=%0d exp=%0d", i, out, exp_out[i]); else passed++;
      if (i == 5) begin
        total++; if (sat !== 1'b0) $display("FAIL up_sat_early act=%b exp=0", sat); else passed++;
      end
    end
    total++; if (sat !== 1'b1) $display("FAIL up_sat_flag act=%b exp=1", sat); else passed++;
    total++; if (at_max !== 1'b1) $display("FAIL up_sat_at_max act=%b exp=1", at_max); else passed++;
    idle();
  endtask

  task automatic test_up_wrap();
    do_reset();
    load_min = 1; min_in = 8'd5; load_max = 1; max_in = 8'd12;
    tick();
    idle();
    wrap_mode = 1; load = 1; in = 8'd10;
    tick();
    total++; if (out !== 8'd10) $display("FAIL wrap_load act=%0d exp=10", out); else passed++;
    load = 0; up = 1; step = 4'd2;
    tick();
    total++; if ({out, wrap, at_max} !== {8'd12, 1'b0, 1'b1})
      $display("FAIL wrap_to12 act=%0d/%b/%b exp=12/0/1", out, wrap, at_max); else passed++;
    tick();
    total++; if ({out, wrap, at_min} !== {8'd5, 1'b1, 1'b1})
      $display("FAIL wrap_to5 act=%0d/%b/%b exp=5/1/1", out, wrap, at_min); else passed++;
    up = 0;
    tick();
    total++; if ({out, wrap} !== {8'd5, 1'b0}) $display("FAIL wrap_pulse_end act=%0d/%b exp=5/0", out, wrap); else passed++;
    idle();
  endtask

  task automatic test_down_saturate();
    do_reset();
    load_min = 1; min_in = 8'd5;
    tick();
    idle();
    load = 1; in = 8'd6;
    tick();
    load = 0; down = 1; step = 4'd4;
    tick();
    total++; if ({out, sat, at_min} !== {8'd5, 1'b1, 1'b1})
      $display("FAIL down_sat act=%0d/%b/%b exp=5/1/1", out, sat, at_min); else passed++;
    flag_clr = 1;
    tick();
    total++; if (sat !== 1'b1) $display("FAIL sat_set_wins act=%b exp=1", sat); else passed++;
    down = 0;
    tick();
    total++; if (sat !== 1'b0) $display("FAIL sat_clear act=%b exp=0", sat); else passed++;
    idle();
  endtask

  task automatic test_bound_change();
    do_reset();
    load = 1; in = 8'd30;
    tick();
    idle();
    load_max = 1; max_in = 8'd15;
    tick();
    idle();
    total++; if (out !== 8'd30) $display("FAIL bound_load_edge act=%0d exp=30", out); else passed++;
    tick();
    total++; if ({out, sat, wrap, at_max} !== {8'd15, 1'b0, 1'b0, 1'b1})
      $display("FAIL bound_clamp act=%0d/%b/%b/%b exp=15/0/0/1", out, sat, wrap, at_max); else passed++;
  endtask

  task automatic test_cfg_err();
    do_reset();
    load_max = 1; max_in = 8'd100;
    tick();
    idle();
    load_min = 1; min_in = 8'd200;
    tick();
    idle();
    total++; if (cfg_err !== 1'b1) $display("FAIL cfg_err act=%b exp=1", cfg_err); else passed++;
    up = 1; step = 4'd3;
    tick();
    total++; if (out !== 8'd0) $display("FAIL cfg_up_ignored act=%0d exp=0", out); else passed++;
    up = 0; down = 1;
    tick();
    total++; if (out !== 8'd0) $display("FAIL cfg_down_ignored act=%0d exp=0", out); else passed++;
    down = 0; clr = 1;
    tick();
    total++; if (out !== 8'd200) $display("FAIL cfg_clr act=%0d exp=200", out); else passed++;
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    load_max = 1; max_in = 8'd3; wrap_mode = 1;
    tick();
    load_max = 0; up = 1; step = 4'd1;
    for (int i = 0; i < 4; i++) tick();
    total++; if ({out, wrap} !== {8'd0, 1'b1}) $display("FAIL pre_reset_wrap act=%0d/%b exp=0/1", out, wrap); else passed++;
    idle();
    load = 1; in = 8'd2;
    tick();
    load = 0;
    #2 rst = 0;
    #1;
    total++; if ({out, at_max, at_min, wrap, sat} !== {8'd0, 4'b0100})
      $display("FAIL async_reset act=%0d/%b%b%b%b exp=0/0100", out, at_max, at_min, wrap, sat); else passed++;
    @(negedge clk);
    rst = 1;
    load = 1; in = 8'd7;
    tick();
    load = 0; up = 1; down = 1; step = 4'd1;
    tick();
    total++; if (out !== 8'd7) $display("FAIL up_down_hold act=%0d exp=7", out); else passed++;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_up_saturate();
    test_up_wrap();
    test_down_saturate();
    test_bound_change();
    test_cfg_err();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
